fetch_port: RTL and testbench

Instruction-side memory responder that serves the core fetch unit. It accepts the fetch unit's byte address, returns a 32-bit instruction word, and asserts `hold` until that word is available. Words are assembled from two beats of a 16-bit req/ack external bus into a two-entry word buffer, with sequential prefetch of the next word. It sits between the fetch unit and the instruction bus arbiter.

---
 rtl/fetch_port.sv | 166 ++++++++++++++++
 tb/tb_fetch_port.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_port.sv
// rtl/fetch_port.sv - instruction fetch responder with two-entry word buffer and sequential prefetch
module fetch_port #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              a_rst,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              flush,
  output logic [31:0]       fetch_opc,
  output logic              hold,
  output logic              ext_req,
  output logic [ADDR_W-1:0] ext_addr,
  input  logic              ext_ack,
  input  logic [15:0]       ext_data
);

  localparam int TAG_W = ADDR_W - 2;

  typedef enum logic [1:0] {S_IDLE, S_HI, S_LO} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              valid_q, valid_d;
  logic [1:0][TAG_W-1:0]   tag_q, tag_d;
  logic [1:0][31:0]        data_q, data_d;
  logic                    lru_q, lru_d;
  logic                    discard_q, discard_d;
  logic                    dest_q, dest_d;
  logic [TAG_W-1:0]        ftag_q, ftag_d;
  logic                    ext_req_q, ext_req_d;
  logic [ADDR_W-1:0]       ext_addr_q, ext_addr_d;

  logic [TAG_W-1:0]        cur_tag, next_tag, st_tag;
  logic [1:0]              hit_vec;
  logic                    hit, hit_idx, next_present, start, st_dest;

  // Byte offset within a word plays no part in fetch.
  logic                    unused_pc_bits;
  assign unused_pc_bits = ^pc_addr[1:0];

  assign cur_tag  = pc_addr[ADDR_W-1:2];
  assign next_tag = cur_tag + TAG_W'(1);

  assign hit_vec[0]   = valid_q[0] && (tag_q[0] == cur_tag);
  assign hit_vec[1]   = valid_q[1] && (tag_q[1] == cur_tag);
  assign hit          = |hit_vec;
  assign hit_idx      = !hit_vec[0];
  assign next_present = (valid_q[0] && (tag_q[0] == next_tag)) ||
                        (valid_q[1] && (tag_q[1] == next_tag));

  assign fetch_opc = hit ? data_q[hit_idx] : 32'h0;
  assign hold      = !hit;
  assign ext_req   = ext_req_q;
  assign ext_addr  = ext_addr_q;

  // Demand miss beats prefetch; a prefetch goes into the entry not being hit.
  always_comb begin
    start   = 1'b0;
    st_tag  = cur_tag;
    st_dest = lru_q;
    if (!hit) begin
      start = 1'b1;
    end else if (!next_present) begin
      start   = 1'b1;
      st_tag  = next_tag;
      st_dest = !hit_idx;
    end
  end

  // Next-state: engine sequencing, buffer fill, LRU and flush handling.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;
    lru_d      = lru_q;
    discard_d  = discard_q;
    dest_d     = dest_q;
    ftag_d     = ftag_q;
    ext_req_d  = ext_req_q;
    ext_addr_d = ext_addr_q;

    if (hit) begin
      lru_d = !hit_idx;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d          = S_HI;
          ftag_d           = st_tag;
          dest_d           = st_dest;
          valid_d[st_dest] = 1'b0;
          discard_d        = 1'b0;
          ext_req_d        = 1'b1;
          ext_addr_d       = {st_tag, 2'b00};
        end
      end
      S_HI: begin
        if (ext_ack) begin
          data_d[dest_q][31:16] = ext_data;
          ext_addr_d            = {ftag_q, 2'b10};
          state_d               = S_LO;
        end
      end
      S_LO: begin
        if (ext_ack) begin
          data_d[dest_q][15:0] = ext_data;
          state_d              = S_IDLE;
          ext_req_d            = 1'b0;
          if (!discard_q && !flush) begin
            valid_d[dest_q] = 1'b1;
            tag_d[dest_q]   = ftag_q;
            lru_d           = !dest_q;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        ext_req_d = 1'b0;
      end
    endcase

    // Flush wins over any same-cycle fill; a running transaction finishes but is discarded.
    if (flush) begin
      valid_d = '0;
      if (state_q != S_IDLE) begin
        discard_d = 1'b1;
      end
    end
  end

  // Engine state register.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Buffer, LRU and bus registers.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      valid_q    <= '0;
      tag_q      <= '0;
      data_q     <= '0;
      lru_q      <= 1'b0;
      discard_q  <= 1'b0;
      dest_q     <= 1'b0;
      ftag_q     <= '0;
      ext_req_q  <= 1'b0;
      ext_addr_q <= '0;
    end else begin
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      lru_q      <= lru_d;
      discard_q  <= discard_d;
      dest_q     <= dest_d;
      ftag_q     <= ftag_d;
      ext_req_q  <= ext_req_d;
      ext_addr_q <= ext_addr_d;
    end
  end

endmodule

// File: tb/tb_fetch_port.sv
// tb/tb_fetch_port.sv - self-checking bench for fetch_port
module tb_fetch_port;

  logic        clk;
  logic        a_rst;
  logic [15:0] pc_addr;
  logic        flush;
  logic [31:0] fetch_opc;
  logic        hold;
  logic        ext_req;
  logic [15:0] ext_addr;
  logic        ext_ack;
  logic [15:0] ext_data;

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_port #(.ADDR_W(16)) dut (
    .clk      (clk),
    .a_rst    (a_rst),
    .pc_addr  (pc_addr),
    .flush    (flush),
    .fetch_opc(fetch_opc),
    .hold     (hold),
    .ext_req  (ext_req),
    .ext_addr (ext_addr),
    .ext_ack  (ext_ack),
    .ext_data (ext_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory: two fixed beats at 0/2, a scrambled address pattern elsewhere.
  function automatic logic [15:0] mem16(input logic [15:0] a);
    if (a == 16'h0000) return 16'h1234;
    if (a == 16'h0002) return 16'h5678;
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  function automatic logic [31:0] word(input logic [13:0] t);
    return {mem16({t, 2'b00}), mem16({t, 2'b10})};
  endfunction

  assign ext_data = mem16(ext_addr);

  task automatic chk(input string name, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %h expected %h", name, what, act, exp);
    end
  endtask

  task automatic cyc(input string name, input logic [15:0] pc, input logic ack, input logic fl,
                     input logic e_hold, input logic e_req, input logic [15:0] e_addr, input logic [31:0] e_opc);
    pc_addr = pc;
    ext_ack = ack;
    flush   = fl;
    #2;
    chk(name, "hold", 32'(hold), 32'(e_hold));
    chk(name, "ext_req", 32'(ext_req), 32'(e_req));
    chk(name, "ext_addr", 32'(ext_addr), 32'(e_addr));
    chk(name, "fetch_opc", fetch_opc, e_opc);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_rst   = 1'b0;
    pc_addr = 16'h0;
    flush   = 1'b0;
    ext_ack = 1'b0;
    @(posedge clk);
    #1;
    a_rst = 1'b1;
  endtask

  typedef struct {
    logic [15:0] pc;
    logic        ack;
    logic        hold;
    logic        req;
    logic [15:0] addr;
    logic [31:0] opc;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] pc, input logic ack, input logic h,
                              input logic r, input logic [15:0] a, input logic [31:0] o);
    vec_t v;
    v.pc = pc; v.ack = ack; v.hold = h; v.req = r; v.addr = a; v.opc = o;
    return v;
  endfunction

  vec_t tbl[18];

  // Reference model state: entries hold memory words by tag, engine tracked as beats left.
  logic [1:0]  mv;
  logic [13:0] mt[2];
  logic        mlru;
  int          left;
  logic [13:0] mftag;
  logic        mdest;
  logic        mdisc;

  initial begin
    logic [31:0] w0;
    logic [15:0] pc;
    logic        ack, fl, last_hold;
    logic [13:0] cur, nxt;
    logic        h0, h1, hit, hidx, nxt_in, busy_before;

    w0 = 32'h12345678;

    // Reset state, checked before any clock edge.
    a_rst = 1'b0; pc_addr = 16'h0; flush = 1'b0; ext_ack = 1'b0;
    #3;
    chk("reset", "hold", 32'(hold), 32'd1);
    chk("reset", "ext_req", 32'(ext_req), 32'd0);
    chk("reset", "ext_addr", 32'(ext_addr), 32'h0);
    chk("reset", "fetch_opc", fetch_opc, 32'h0);
    @(posedge clk);
    #1;
    a_rst = 1'b1;

    // Cold start, prefetch, sequential stepping and victim alternation.
    tbl[0]  = mk(16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 32'h0);
    tbl[1]  = mk(16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000, 32'h0);
    tbl[2]  = mk(16'h0000, 1'b1, 1'b1, 1'b1, 16'h0002, 32'h0);
    tbl[3]  = mk(16'h0000, 1'b1, 1'b0, 1'b0, 16'h0002, w0);
    tbl[4]  = mk(16'h0000, 1'b1, 1'b0, 1'b1, 16'h0004, w0);
    tbl[5]  = mk(16'h0000, 1'b1, 1'b0, 1'b1, 16'h0006, w0);
    tbl[6]  = mk(16'h0000, 1'b1, 1'b0, 1'b0, 16'h0006, w0);
    tbl[7]  = mk(16'h0004, 1'b1, 1'b0, 1'b0, 16'h0006, word(14'h1));
    tbl[8]  = mk(16'h0004, 1'b1, 1'b0, 1'b1, 16'h0008, word(14'h1));
    tbl[9]  = mk(16'h0004, 1'b1, 1'b0, 1'b1, 16'h000A, word(14'h1));
    tbl[10] = mk(16'h0008, 1'b1, 1'b0, 1'b0, 16'h000A, word(14'h2));
    tbl[11] = mk(16'h0008, 1'b1, 1'b0, 1'b1, 16'h000C, word(14'h2));
    tbl[12] = mk(16'h0008, 1'b1, 1'b0, 1'b1, 16'h000E, word(14'h2));
    tbl[13] = mk(16'h0000, 1'b1, 1'b1, 1'b0, 16'h000E, 32'h0);
    tbl[14] = mk(16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000, 32'h0);
    tbl[15] = mk(16'h0000, 1'b1, 1'b1, 1'b1, 16'h0002, 32'h0);
    tbl[16] = mk(16'h0000, 1'b1, 1'b0, 1'b0, 16'h0002, w0);
    tbl[17] = mk(16'h0000, 1'b0, 1'b0, 1'b1, 16'h0004, w0);
    for (int i = 0; i < 18; i++) begin
      cyc($sformatf("seq%0d", i), tbl[i].pc, tbl[i].ack, 1'b0, tbl[i].hold, tbl[i].req, tbl[i].addr, tbl[i].opc);
    end

    // Redirect while the prefetch HI beat waits three cycles for ack.
    cyc("redir_w1", 16'h0100, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0004, 32'h0);
    cyc("redir_w2", 16'h0100, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0004, 32'h0);
    cyc("redir_hi", 16'h0100, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0004, 32'h0);
    cyc("redir_lo", 16'h0100, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0006, 32'h0);
    cyc("redir_idle", 16'h0100, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0006, 32'h0);
    cyc("redir_dhi", 16'h0100, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0100, 32'h0);
    cyc("redir_dlo", 16'h0100, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0102, 32'h0);
    cyc("redir_hit", 16'h0100, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0102, word(14'h40));

    // Flush during the LO beat of a fill.
    do_reset();
    cyc("fl0", 16'h0040, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 32'h0);
    cyc("fl1", 16'h0040, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0040, 32'h0);
    cyc("fl2", 16'h0040, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0042, 32'h0);
    cyc("fl3", 16'h0040, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0042, 32'h0);
    cyc("fl4", 16'h0040, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0040, 32'h0);
    cyc("fl5", 16'h0040, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0042, 32'h0);
    cyc("fl6", 16'h0040, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0042, word(14'h10));

    // Tag wrap-around on prefetch.
    do_reset();
    cyc("wr0", 16'hFFFC, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 32'h0);
    cyc("wr1", 16'hFFFC, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFC, 32'h0);
    cyc("wr2", 16'hFFFC, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFE, 32'h0);
    cyc("wr3", 16'hFFFC, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFE, word(14'h3FFF));
    cyc("wr4", 16'hFFFC, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, word(14'h3FFF));
    cyc("wr5", 16'hFFFC, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0002, word(14'h3FFF));
    cyc("wr6", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, w0);

    // Asynchronous reset in the middle of a HI beat.
    do_reset();
    cyc("ar0", 16'h0080, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 32'h0);
    cyc("ar1", 16'h0080, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0080, 32'h0);
    #2;
    a_rst = 1'b0;
    #1;
    chk("arst", "ext_req", 32'(ext_req), 32'd0);
    chk("arst", "hold", 32'(hold), 32'd1);
    chk("arst", "fetch_opc", fetch_opc, 32'h0);
    chk("arst", "ext_addr", 32'(ext_addr), 32'h0);
    @(posedge clk);
    #1;
    a_rst = 1'b1;

    // Randomised traffic against the reference model.
    do_reset();
    mv = '0; mt[0] = '0; mt[1] = '0; mlru = 1'b0; left = 0; mftag = '0; mdest = 1'b0; mdisc = 1'b0;
    pc = 16'h0;
    last_hold = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 55 && !last_hold) begin
        pc = pc + 16'd4;
      end else if (r >= 80) begin
        if ($urandom_range(0, 9) == 0) pc = 16'hFFF8 + 16'($urandom_range(0, 7));
        else                           pc = 16'($urandom_range(0, 127));
      end
      ack = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 59) == 0);
      pc_addr = pc;
      ext_ack = ack;
      flush   = fl;
      #2;

      cur  = pc[15:2];
      nxt  = cur + 14'd1;
      h0   = mv[0] && (mt[0] == cur);
      h1   = mv[1] && (mt[1] == cur);
      hit  = h0 || h1;
      hidx = !h0;
      nxt_in = (mv[0] && (mt[0] == nxt)) || (mv[1] && (mt[1] == nxt));

      chk("rnd", "hold", 32'(hold), 32'(!hit));
      chk("rnd", "fetch_opc", fetch_opc, hit ? word(cur) : 32'h0);
      chk("rnd", "ext_req", 32'(ext_req), 32'(left != 0));
      if (left != 0) begin
        chk("rnd", "ext_addr", 32'(ext_addr), 32'({mftag, 2'b00} + ((left == 1) ? 16'd2 : 16'd0)));
      end
      last_hold = !hit;

      busy_before = (left != 0);
      if (hit) mlru = !hidx;
      if (left == 0) begin
        if (!hit || !nxt_in) begin
          mftag = hit ? nxt : cur;
          mdest = hit ? !hidx : mlru;
          left  = 2;
          mv[mdest] = 1'b0;
          mdisc = 1'b0;
        end
      end else if (ack) begin
        left--;
        if (left == 0 && !mdisc && !fl) begin
          mv[mdest] = 1'b1;
          mt[mdest] = mftag;
          mlru      = !mdest;
        end
      end
      if (fl) begin
        if (busy_before) mdisc = 1'b1;
        mv = '0;
      end

      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
